// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg: shared encodings and default widths for the pipeline memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int AW_DEFAULT = 32;
   localparam int DW_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      IF_BUSY  = 3'd1,
      MEM_BUSY = 3'd2,
      MEM_DONE = 3'd3,
      IF_DONE  = 3'd4
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
// ============================================================================
// imem_dmem_arbiter: shares one SRAM port between fetch and MEM, with stalls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_dmem_arbiter
   import pipe_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          branch_taken,
   output logic          if_valid,
   output logic [DW-1:0] if_instr,
   output logic          freeze_if,
   input  logic          mem_rd_en,
   input  logic          mem_wr_en,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] mem_rdata,
   output logic          mem_ready,
   output logic          mem_stall,
   output logic          sram_req,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_wdata,
   input  logic          sram_ack,
   input  logic [DW-1:0] sram_rdata
);

   arb_state_t state;
   arb_state_t next_state;
   logic       drop;
   logic       grant_mem;
   logic       grant_if;

   // MEM wins over IF in IDLE: it holds the older instruction.
   always_comb begin
      next_state = state;
      grant_mem  = 1'b0;
      grant_if   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_rd_en | mem_wr_en) begin
               next_state = MEM_BUSY;
               grant_mem  = 1'b1;
            end else if (if_req) begin
               next_state = IF_BUSY;
               grant_if   = 1'b1;
            end
         end
         IF_BUSY:  if (sram_ack) next_state = IF_DONE;
         MEM_BUSY: if (sram_ack) next_state = MEM_DONE;
         IF_DONE:  next_state = IDLE;
         MEM_DONE: next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         drop       <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         if_instr   <= '0;
         mem_rdata  <= '0;
      end else begin
         state <= next_state;

         // A redirect while the fetch is outstanding makes its result stale.
         if (next_state == IDLE)
            drop <= 1'b0;
         else if (state == IF_BUSY && branch_taken)
            drop <= 1'b1;

         if (grant_mem) begin
            sram_addr  <= mem_addr;
            sram_we    <= mem_wr_en;
            sram_wdata <= mem_wdata;
         end else if (grant_if) begin
            sram_addr  <= if_addr;
            sram_we    <= 1'b0;
         end

         if (state == IF_BUSY && sram_ack)
            if_instr <= sram_rdata;

         if (state == MEM_BUSY && sram_ack) begin
            mem_rdata <= sram_rdata;
            sram_we   <= 1'b0;
         end
      end
   end

   assign sram_req  = (state == IF_BUSY) || (state == MEM_BUSY);
   assign if_valid  = (state == IF_DONE) && !drop;
   assign mem_ready = (state == MEM_DONE);
   assign freeze_if = ~if_valid;
   assign mem_stall = (mem_rd_en | mem_wr_en) & ~mem_ready;

endmodule

`default_nettype wire
